knn_query_ctrl: RTL

Sequencer for the k-NN classifier datapath. It sits between the input front end and the dual-port distance engine. It buffers query points in a small FIFO and issues one query at a time to the engine with a single-cycle start pulse. On the engine's done it captures the five nearest-neighbour class bits, performs the K=3/K=5 majority vote, and presents the prediction with its measured cycle latency on a valid/ready result port.

---
 rtl/knn_pkg.sv | 31 +++
 rtl/knn_query_fifo.sv | 52 +++++
 rtl/knn_query_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared types and constants for the k-NN query sequencer.
`timescale 1ns/1ps
package knn_pkg;

    localparam int COORD_W = 8;
    localparam int CLASS_N = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        VOTE,
        OUT
    } knn_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic                      k5;
    } knn_query_t;

    function automatic logic [2:0] popcount(input logic [CLASS_N-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < CLASS_N; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/knn_query_fifo.sv
// Synchronous FIFO with occupancy level; head word is visible combinationally on rdata.
`timescale 1ns/1ps
module knn_query_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/knn_query_ctrl.sv
// k-NN query sequencer: buffers queries, drives the distance engine, votes and returns results.
// Define KNN_TIMEOUT_EN to enable the WAIT-state watchdog limited by TIMEOUT_CYCLES.
`timescale 1ns/1ps
module knn_query_ctrl
    import knn_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int LAT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      q_valid,
    output logic                      q_ready,
    input  logic signed [COORD_W-1:0] q_x,
    input  logic signed [COORD_W-1:0] q_y,
    input  logic                      q_k5,
    output logic                      eng_start,
    output logic signed [COORD_W-1:0] eng_x,
    output logic signed [COORD_W-1:0] eng_y,
    input  logic                      eng_done,
    input  logic [CLASS_N-1:0]        eng_class,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_class,
    output logic                      res_k5,
    output logic [LAT_W-1:0]          res_latency,
    output logic                      res_timeout,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    // state | meaning
    // IDLE  | waiting for a queued query; pops the FIFO head
    // ISSUE | eng_start pulse, latency counter cleared
    // WAIT  | counting cycles until eng_done (or watchdog expiry)
    // VOTE  | majority vote, result registers loaded
    // OUT   | res_valid held until res_ready

    knn_state_t         state;
    knn_state_t         state_n;
    knn_query_t         q_in;
    knn_query_t         head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               k5_q;
    logic [CLASS_N-1:0] class_q;
    logic [LAT_W-1:0]   cnt;
    logic               to_q;
    logic               wd_expire;
    logic               vote;

    assign q_in     = '{x: q_x, y: q_y, k5: q_k5};
    assign q_ready  = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    knn_query_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(knn_query_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_valid),
        .pop   (fifo_pop),
        .wdata (q_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef KNN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Down-counter reaches zero in the same cycle the latency count reaches TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - WD_W'(1);
        end
    end

    assign wd_expire = (state == WAIT) && (wd_cnt == '0);
`else
    assign wd_expire = 1'b0;
`endif

    assign vote = k5_q ? (popcount(class_q) >= 3'd3)
                       : (popcount({2'b00, class_q[2:0]}) >= 3'd2);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!fifo_empty) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (eng_done || wd_expire) state_n = VOTE;
            VOTE:    state_n = OUT;
            OUT:     if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            eng_start   <= 1'b0;
            eng_x       <= '0;
            eng_y       <= '0;
            k5_q        <= 1'b0;
            class_q     <= '0;
            cnt         <= '0;
            to_q        <= 1'b0;
            res_valid   <= 1'b0;
            res_class   <= 1'b0;
            res_k5      <= 1'b0;
            res_latency <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= state_n;
            eng_start <= (state_n == ISSUE);
            busy      <= (state_n != IDLE);
            res_valid <= (state_n == OUT);
            if (fifo_pop) begin
                eng_x <= head.x;
                eng_y <= head.y;
                k5_q  <= head.k5;
            end
            case (state)
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (cnt != '1) cnt <= cnt + LAT_W'(1);
                    if (eng_done) begin
                        class_q <= eng_class;
                        to_q    <= 1'b0;
                    end else if (wd_expire) begin
                        class_q <= '0;
                        to_q    <= 1'b1;
                    end
                end
                VOTE: begin
                    res_class   <= vote;
                    res_k5      <= k5_q;
                    res_latency <= cnt;
                    res_timeout <= to_q;
                end
                default: ;
            endcase
        end
    end

endmodule
